// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract sequencer: streams operand bit pairs LSB first through one
// full-adder cell and collects sum, carry-out, signed overflow and zero into registered outputs.
module serial_add_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             msb_cin;
    logic [CW-1:0]    count;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_next;

    // The single full-adder cell this sequencer feeds.
    always_comb begin
        fa_s     = op_a[0] ^ op_b[0] ^ carry;
        fa_co    = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
        sum_next = {fa_s, sum[WIDTH-1:1]};
    end

    // Overflow is the XOR of two flops that only change on completion, so it holds like a register.
    assign overflow = msb_cin ^ c_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            sum     <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            c_out   <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN) begin
                sum   <= sum_next;
                carry <= fa_co;
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                count <= count + CW'(1);
                if (count == LAST) begin
                    msb_cin <= carry;
                    result  <= sum_next;
                    c_out   <= fa_co;
                    zero    <= (sum_next == '0);
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
            end else if (start) begin
                // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                op_a  <= a;
                op_b  <= op_sub ? ~b : b;
                carry <= op_sub;
                count <= '0;
                busy  <= 1'b1;
                state <= RUN;
            end else begin
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit at WIDTH=8: latency, flags, ignored start,
// back-to-back acceptance and asynchronous reset abort.
module tb_serial_add_unit;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         zr;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, c_out, overflow, zero;
    logic [W-1:0] result;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    exp_t sb[$];
    exp_t last_exp = '0;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_sub(op_sub),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .c_out(c_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] yy;
        yy    = sub ? ~y : y;
        s     = {1'b0, x} + {1'b0, yy} + (W+1)'(sub);
        e.res = s[W-1:0];
        e.co  = s[W];
        e.zr  = (s[W-1:0] == '0);
        e.ov  = sub ? ((x[W-1] != y[W-1]) && (s[W-1] != x[W-1]))
                    : ((x[W-1] == y[W-1]) && (s[W-1] != x[W-1]));
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("c_out", c_out, e.co);
                chk("overflow", overflow, e.ov);
                chk("zero", zero, e.zr);
                last_exp = e;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_c_out"}, c_out, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_zero"}, zero, 0);
    endtask

    // Counts busy cycles until done, checking that outputs hold meanwhile.
    task automatic wait_done(input string tag, input int exp_busy);
        int nb  = 0;
        bit got = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            if (busy) nb++;
            if (result !== last_exp.res) chk({tag, "_hold"}, result, last_exp.res);
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_busy_cycles"}, nb, exp_busy);
        chk({tag, "_busy_in_done"}, busy, 0);
    endtask

    task automatic accept(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, output bit got);
        got = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_accept"}, got, 1);
        if (got) sb.push_back(model(x, y, sub));
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub);
        bit got;
        @(negedge clk);
        a = x; b = y; op_sub = sub; start = 1'b1;
        accept(tag, x, y, sub, got);
        a = 8'hA5; b = 8'h5A; op_sub = ~sub;
        if (got) wait_done(tag, W);
    endtask

    initial begin
        bit got;
        int nd;

        // Reset held with start asserted.
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("rst");
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        run_op("add_3c_05", 8'h3C, 8'h05, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
        run_op("sub_2a_2a", 8'h2A, 8'h2A, 1'b1);
        repeat (3) @(negedge clk);

        // Start pulsed mid-RUN is ignored.
        @(negedge clk);
        a = 8'h01; b = 8'h01; op_sub = 1'b0; start = 1'b1;
        accept("ign", 8'h01, 8'h01, 1'b0, got);
        repeat (3) @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", W - 4);

        // Start held during DONE is accepted with no IDLE cycle.
        a = 8'h10; b = 8'h20; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_accept", busy, 1);
        sb.push_back(model(8'h10, 8'h20, 1'b0));
        start = 1'b0;
        wait_done("b2b", W);
        @(negedge clk);
        chk("b2b_idle_after", busy, 0);

        // Asynchronous reset during RUN aborts the operation.
        @(negedge clk);
        a = 8'h55; b = 8'h0F; op_sub = 1'b0; start = 1'b1;
        accept("abort", 8'h55, 8'h0F, 1'b0, got);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        sb.delete();
        last_exp = '0;
        nd = n_done;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done, nd);
        chk("abort_idle", busy, 0);
        run_op("add_03_04", 8'h03, 8'h04, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_add_unit.md
# serial_add_unit

Bit-serial add/subtract sequencer that sits directly upstream of the datapath's single-bit full adder. It holds two WIDTH-bit operands and feeds one bit pair plus the running carry into a full-adder cell per clock, LSB first. It collects the sum bits and carry-out into a registered result with flags. It gives the CPU an area-minimal ALU add path that needs exactly one full-adder cell.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request operation; sampled on rising edge of clk
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed (RUN state)
- done  output  1  one-cycle pulse: result and flags just updated
- result  output  WIDTH  registered sum/difference
- c_out  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  result == 0

## Operation
- Fixed decision: one clock (clk); reset is asynchronous and active-low (reset_n).
- Internal state:
  - op_a and op_b shift registers (WIDTH bits each)
  - sum shift register (WIDTH bits)
  - carry flop and MSB carry-in flop
  - bit counter (ceil(log2 WIDTH) bits)
  - FSM
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: op_a<=a, op_b<=(op_sub ? ~b : b), carry<=op_sub, count<=0, go to RUN.
- RUN (busy=1), per edge:
  - The full adder takes x=op_a[0], y=op_b[0], c_in=carry.
  - sum <= {s, sum[WIDTH-1:1]}, carry <= c_out_fa, op_a and op_b shift right by 1, count++.
  - On the edge where count==WIDTH-1, the MSB carry-in flop captures the full adder's c_in. The state then goes to DONE.
  - On that same edge the output registers load:
    - result <= final sum (including this bit)
    - c_out <= full adder's c_out
    - overflow <= c_in XOR c_out of the MSB
    - zero <= (final sum == 0)
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - If start=1, a new operation loads exactly as in IDLE and the FSM goes to RUN (back-to-back).
  - Otherwise the FSM goes to IDLE.
- start while in RUN is ignored: no reload and no effect on the current operation.
- result, c_out, overflow and zero hold their values from completion until the next completion. They do not change during RUN.
- Arithmetic is modulo 2^WIDTH. Subtract is A + ~B + 1. No extra result bit.

## Timing
- Reset value of every output is 0: busy, done, result, c_out, overflow, zero. The FSM resets to IDLE, and all internal registers reset to 0.
- Reset asserted mid-RUN: the operation is aborted immediately, no done pulse occurs, and all outputs clear. After release the unit is in IDLE.
- Start accepted on edge k:
  - busy is high from after edge k until after edge k+WIDTH.
  - Output registers update on edge k+WIDTH.
  - done is high in the cycle between edge k+WIDTH and edge k+WIDTH+1.
- Latency is WIDTH+1 edges from start acceptance to the end of the done cycle.
- Back-to-back throughput is one operation per WIDTH+1 cycles.
- a, b and op_sub are sampled only on the accepting edge and may change afterward.

## Test plan
- **Reset:** hold reset_n=0, toggle clk, drive start=1.
  - Required: all outputs 0 and busy stays 0.
  - Release reset with start=0: done never pulses.
- **Add with exact latency (WIDTH=8):** a=8'h3C, b=8'h05, op_sub=0, start accepted on edge k.
  - Required: busy high for 8 cycles, then done high in the cycle after edge k+8.
  - result=8'h41, c_out=0, overflow=0, zero=0.
- **Carry and flags:** 8'hFF+8'h01 -> result=8'h00, c_out=1, zero=1, overflow=0.
  - 8'h7F+8'h01 -> result=8'h80, c_out=0, overflow=1, zero=0.
- **Subtract:** 8'h05-8'h07 -> result=8'hFE, c_out=0, overflow=0.
  - 8'h80-8'h01 -> result=8'h7F, c_out=1, overflow=1.
  - 8'h2A-8'h2A -> result=8'h00, zero=1, c_out=1.
- **Ignored start and back-to-back:** pulse start with a=8'h11, b=8'h22 mid-RUN of 8'h01+8'h01.
  - Required: the result is 8'h02, unaffected.
  - Then hold start=1 during DONE with 8'h10+8'h20: it is accepted with no IDLE cycle, and result=8'h30 appears 9 cycles later.
- **Reset mid-operation:** assert reset_n=0 asynchronously at cycle 4 of a RUN.
  - Required: busy and all outputs drop to 0 immediately, and no done pulse occurs.
  - After release, a fresh 8'h03+8'h04 gives result=8'h07.
